// File: rtl/decode_instr_queue_if.sv
// Fetch/decode handshake bundle for decode_instr_queue.
// master: fetch side plus decode stall (drives in_*, stall; observes out_*, fetch_stall).
// slave : the queue itself (consumes in_*, stall; drives out_*, fetch_stall).
interface decode_instr_queue_if #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned PC_WIDTH  = 32,
   parameter int unsigned EXC_WIDTH = 8
);
   logic                 in_valid;
   logic [WIDTH-1:0]     in_instr;
   logic [PC_WIDTH-1:0]  in_pc;
   logic [EXC_WIDTH-1:0] in_exc;
   logic                 stall;
   logic                 out_valid;
   logic [WIDTH-1:0]     out_instr;
   logic [PC_WIDTH-1:0]  out_pc;
   logic [EXC_WIDTH-1:0] out_exc;
   logic                 fetch_stall;

   modport master (
      output in_valid, in_instr, in_pc, in_exc, stall,
      input  out_valid, out_instr, out_pc, out_exc, fetch_stall
   );

   modport slave (
      input  in_valid, in_instr, in_pc, in_exc, stall,
      output out_valid, out_instr, out_pc, out_exc, fetch_stall
   );
endinterface

// File: rtl/decode_instr_queue.sv
// Fetch-to-decode FWFT instruction queue with fetch backpressure, post-flush
// wrong-path discard and sticky overflow detection.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   clk_en, halt  freeze all state when clk_en=0 or halt=1
//   flush         pipeline redirect, empties the queue
//   bus           fetch input / decode output handshake (slave modport)
//   count         current occupancy
//   overflow      sticky: a word arrived into a full, non-popping queue
module decode_instr_queue #(
   parameter int unsigned WIDTH         = 32,
   parameter int unsigned PC_WIDTH      = 32,
   parameter int unsigned EXC_WIDTH     = 8,
   parameter int unsigned DEPTH         = 4,
   parameter int unsigned SKID          = 2,
   parameter int unsigned FLUSH_DISCARD = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         clk_en,
   input  logic                         halt,
   input  logic                         flush,
   decode_instr_queue_if.slave          bus,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         overflow
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned DW = (FLUSH_DISCARD > 0) ? $clog2(FLUSH_DISCARD + 1) : 1;

   typedef struct packed {
      logic [EXC_WIDTH-1:0] exc;
      logic [PC_WIDTH-1:0]  pc;
      logic [WIDTH-1:0]     instr;
   } entry_t;

   entry_t          mem [DEPTH];
   logic [AW-1:0]   rd_ptr;
   logic [AW-1:0]   wr_ptr;
   logic [DW-1:0]   discard;

   logic            enable_c;
   logic            full_c;
   logic            pop_c;
   logic            accept_c;
   logic            drop_full_c;

   // Datapath qualifiers derived from registered state and this cycle's inputs
   always_comb begin
      enable_c    = clk_en && !halt;
      full_c      = (count == CW'(DEPTH));
      pop_c       = (count != '0) && !bus.stall && !flush;
      accept_c    = bus.in_valid && !flush && (discard == '0) && (!full_c || pop_c);
      drop_full_c = bus.in_valid && !flush && (discard == '0) && full_c && !pop_c;
   end

   // Head is presented combinationally; a fresh push shows up only after its write edge
   always_comb begin
      bus.out_valid   = (count != '0);
      bus.out_instr   = mem[rd_ptr].instr;
      bus.out_pc      = mem[rd_ptr].pc;
      bus.out_exc     = mem[rd_ptr].exc;
      // Leaves room for the SKID words already requested from memory
      bus.fetch_stall = (count >= CW'(DEPTH - SKID));
   end

   // Queue state; flush wins over same-cycle push/pop
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         discard  <= '0;
         overflow <= 1'b0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i] <= '0;
         end
      end else if (enable_c) begin
         if (flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            discard <= DW'(FLUSH_DISCARD);
         end else begin
            if (accept_c) begin
               mem[wr_ptr] <= '{exc: bus.in_exc, pc: bus.in_pc, instr: bus.in_instr};
               wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop_c) begin
               rd_ptr <= rd_ptr + AW'(1);
            end
            case ({accept_c, pop_c})
               2'b10:   count <= count + CW'(1);
               2'b01:   count <= count - CW'(1);
               default: count <= count;
            endcase
            if (discard != '0) begin
               discard <= discard - DW'(1);
            end
            if (drop_full_c) begin
               overflow <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_decode_instr_queue.sv
// Scoreboard bench for decode_instr_queue (DEPTH=4, SKID=2, FLUSH_DISCARD=2).
module tb_decode_instr_queue;
   logic       clk;
   logic       rst;
   logic       clk_en;
   logic       halt;
   logic       flush;
   logic [2:0] count;
   logic       overflow;

   int n_chk;
   int n_fail;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [7:0]  exc;
   } exp_t;

   exp_t sb[$];

   decode_instr_queue_if #(.WIDTH(32), .PC_WIDTH(32), .EXC_WIDTH(8)) bus ();

   decode_instr_queue #(
      .WIDTH(32), .PC_WIDTH(32), .EXC_WIDTH(8),
      .DEPTH(4), .SKID(2), .FLUSH_DISCARD(2)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .clk_en   (clk_en),
      .halt     (halt),
      .flush    (flush),
      .bus      (bus),
      .count    (count),
      .overflow (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive one cycle; acc=1 means this word is expected to enter the queue
   task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic [7:0] exc, input logic acc);
      bus.in_valid = v;
      bus.in_instr = ins;
      bus.in_pc    = pc;
      bus.in_exc   = exc;
      @(posedge clk);
      #1;
      if (acc) sb.push_back('{instr: ins, pc: pc, exc: exc});
      bus.in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 32'h0, 8'h0, 1'b0);
   endtask

   // Monitor: whenever decode takes the head, compare it against the scoreboard front
   always @(negedge clk) begin
      if (!rst && clk_en && !halt && !flush && !bus.stall && bus.out_valid) begin
         if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL pop_unexpected: got instr %0h expected no pop", bus.out_instr);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("pop_head", {bus.out_instr, bus.out_pc, bus.out_exc}, {e.instr, e.pc, e.exc});
         end
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      sb.delete();
   endtask

   initial begin
      n_chk = 0;
      n_fail = 0;
      rst = 1'b1;
      clk_en = 1'b1;
      halt = 1'b0;
      flush = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_instr = '0;
      bus.in_pc = '0;
      bus.in_exc = '0;
      bus.stall = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset state
      chk("rst_out_valid", 72'(bus.out_valid), 72'd0);
      chk("rst_fetch_stall", 72'(bus.fetch_stall), 72'd0);
      chk("rst_count", 72'(count), 72'd0);
      chk("rst_overflow", 72'(overflow), 72'd0);
      chk("rst_out_data", {bus.out_instr, bus.out_pc, bus.out_exc}, 72'd0);

      // 1: three back-to-back pushes, decode free-running
      bus.stall = 1'b0;
      drive(1'b1, 32'h11, 32'h0, 8'h0, 1'b1);
      chk("t1_valid_after_push", 72'(bus.out_valid), 72'd1);
      chk("t1_count1", 72'(count), 72'd1);
      drive(1'b1, 32'h22, 32'h4, 8'h0, 1'b1);
      chk("t1_count2", 72'(count), 72'd1);
      drive(1'b1, 32'h33, 32'h8, 8'h0, 1'b1);
      chk("t1_count3", 72'(count), 72'd1);
      idle(1);
      chk("t1_empty", 72'(count), 72'd0);
      chk("t1_sb_empty", 72'(sb.size()), 72'd0);

      // 2: stalled fill, backpressure, overflow, ordered drain
      bus.stall = 1'b1;
      drive(1'b1, 32'h01, 32'h100, 8'h0, 1'b1);
      chk("t2_fs_c1", 72'(bus.fetch_stall), 72'd0);
      drive(1'b1, 32'h02, 32'h104, 8'h0, 1'b1);
      chk("t2_count2", 72'(count), 72'd2);
      chk("t2_fs_c2", 72'(bus.fetch_stall), 72'd1);
      drive(1'b1, 32'h03, 32'h108, 8'h0, 1'b1);
      chk("t2_head_hold3", 72'(bus.out_instr), 72'h01);
      drive(1'b1, 32'h04, 32'h10c, 8'h0, 1'b1);
      chk("t2_count4", 72'(count), 72'd4);
      chk("t2_head_hold4", 72'(bus.out_instr), 72'h01);
      chk("t2_no_ovf_yet", 72'(overflow), 72'd0);
      drive(1'b1, 32'h05, 32'h110, 8'h0, 1'b0);
      chk("t2_overflow", 72'(overflow), 72'd1);
      chk("t2_count_after_ovf", 72'(count), 72'd4);
      chk("t2_head_hold5", 72'(bus.out_instr), 72'h01);
      bus.stall = 1'b0;
      idle(4);
      chk("t2_drained", 72'(count), 72'd0);
      chk("t2_sb_empty", 72'(sb.size()), 72'd0);
      chk("t2_ovf_sticky", 72'(overflow), 72'd1);

      // 3: full queue streaming through pointer wrap
      do_reset();
      bus.stall = 1'b1;
      for (int i = 0; i < 4; i++) drive(1'b1, 32'h100 + 32'(i), 32'(4 * i), 8'h0, 1'b1);
      chk("t3_full", 72'(count), 72'd4);
      bus.stall = 1'b0;
      for (int i = 4; i < 14; i++) begin
         drive(1'b1, 32'h100 + 32'(i), 32'(4 * i), 8'h0, 1'b1);
         chk("t3_count_full", 72'(count), 72'd4);
         chk("t3_no_ovf", 72'(overflow), 72'd0);
      end
      idle(4);
      chk("t3_drained", 72'(count), 72'd0);
      chk("t3_sb_empty", 72'(sb.size()), 72'd0);

      // 4: flush with live input, discard window and its restart
      bus.stall = 1'b1;
      for (int i = 0; i < 3; i++) drive(1'b1, 32'h200 + 32'(i), 32'(4 * i), 8'h0, 1'b1);
      chk("t4_count3", 72'(count), 72'd3);
      flush = 1'b1;
      drive(1'b1, 32'hbad, 32'h0, 8'h0, 1'b0);
      flush = 1'b0;
      sb.delete();
      chk("t4_flush_count", 72'(count), 72'd0);
      chk("t4_flush_valid", 72'(bus.out_valid), 72'd0);
      drive(1'b1, 32'hd1, 32'h0, 8'h0, 1'b0);
      chk("t4_discard1", 72'(count), 72'd0);
      drive(1'b1, 32'hd2, 32'h0, 8'h0, 1'b0);
      chk("t4_discard2", 72'(count), 72'd0);
      chk("t4_discard_no_ovf", 72'(overflow), 72'd0);
      drive(1'b1, 32'h31, 32'h40, 8'h0, 1'b1);
      chk("t4_accept3rd", 72'(count), 72'd1);
      flush = 1'b1;
      drive(1'b1, 32'hd3, 32'h0, 8'h0, 1'b0);
      flush = 1'b0;
      sb.delete();
      drive(1'b1, 32'hd4, 32'h0, 8'h0, 1'b0);
      chk("t4_win_a", 72'(count), 72'd0);
      flush = 1'b1;
      drive(1'b1, 32'hd5, 32'h0, 8'h0, 1'b0);
      flush = 1'b0;
      drive(1'b1, 32'hd6, 32'h0, 8'h0, 1'b0);
      chk("t4_restart1", 72'(count), 72'd0);
      drive(1'b1, 32'hd7, 32'h0, 8'h0, 1'b0);
      chk("t4_restart2", 72'(count), 72'd0);
      drive(1'b1, 32'h32, 32'h44, 8'h0, 1'b1);
      chk("t4_accept_after", 72'(count), 72'd1);
      chk("t4_head", 72'(bus.out_instr), 72'h32);
      bus.stall = 1'b0;
      idle(1);
      chk("t4_sb_empty", 72'(sb.size()), 72'd0);

      // 5: halt then clock-enable freeze, reset during halt
      bus.stall = 1'b1;
      for (int i = 0; i < 4; i++) drive(1'b1, 32'h300 + 32'(i), 32'(4 * i), 8'h0, 1'b1);
      drive(1'b1, 32'h3ff, 32'h0, 8'h0, 1'b0);
      chk("t5_ovf_set", 72'(overflow), 72'd1);
      halt = 1'b1;
      for (int i = 0; i < 5; i++) begin
         bus.stall = i[0];
         drive(!i[0], 32'h3e0 + 32'(i), 32'h0, 8'h0, 1'b0);
         chk("t5_halt_count", 72'(count), 72'd4);
         chk("t5_halt_head", {bus.out_instr, bus.out_pc, bus.out_exc}, {32'h300, 32'h0, 8'h0});
         chk("t5_halt_ovf", 72'(overflow), 72'd1);
      end
      halt = 1'b0;
      clk_en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         bus.stall = !i[0];
         drive(i[0], 32'h3f0 + 32'(i), 32'h0, 8'h0, 1'b0);
         chk("t5_cen_count", 72'(count), 72'd4);
         chk("t5_cen_head", 72'(bus.out_instr), 72'h300);
      end
      clk_en = 1'b1;
      halt = 1'b1;
      do_reset();
      chk("t5_rst_count", 72'(count), 72'd0);
      chk("t5_rst_valid", 72'(bus.out_valid), 72'd0);
      chk("t5_rst_ovf", 72'(overflow), 72'd0);
      chk("t5_rst_data", {bus.out_instr, bus.out_pc, bus.out_exc}, 72'd0);
      halt = 1'b0;

      // 6: exception code travels with its instruction
      bus.stall = 1'b1;
      drive(1'b1, 32'h55, 32'h40, 8'h80, 1'b1);
      chk("t6_exc_head", {bus.out_pc, bus.out_exc}, {32'h40, 8'h80});
      drive(1'b1, 32'h66, 32'h44, 8'h00, 1'b1);
      bus.stall = 1'b0;
      idle(1);
      chk("t6_next_exc", {bus.out_instr, bus.out_exc}, {32'h66, 8'h00});
      idle(1);
      chk("t6_sb_empty", 72'(sb.size()), 72'd0);
      chk("t6_empty", 72'(count), 72'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/decode_instr_queue.md
Name: decode_instr_queue

Overview:
- Parametrised fetch-to-decode instruction queue.
- Replaces the fixed two-cycle stall instruction buffer in front of decode with a DEPTH-entry first-word-fall-through (FWFT) FIFO.
- Adds fetch backpressure sized to the memory latency, wrong-path discard after flush, and overflow detection.
- Sits between the instruction-memory read port and the decode stage; decode consumes the head entry.

Parameters:
- WIDTH, 32, instruction word width.
- PC_WIDTH, 32, PC width.
- EXC_WIDTH, 8, fetch exception code width.
- DEPTH, 4, queue entries; power of two, >= 2.
- SKID, 2, fetch-to-data latency in cycles; must satisfy SKID < DEPTH.
- FLUSH_DISCARD, 2, cycles after a flush during which arriving fetch data is wrong-path and is dropped.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- clk_en  in  1  global clock enable; 0 freezes all state.
- halt  in  1  1 freezes all state.
- flush  in  1  pipeline redirect; empties the queue.
- in_valid  in  1  memory returns a fetched word this cycle (inverse of the fetch bubble).
- in_instr  in  WIDTH  fetched instruction.
- in_pc  in  PC_WIDTH  PC of the fetched instruction.
- in_exc  in  EXC_WIDTH  fetch exception code; 0 = none.
- stall  in  1  decode cannot accept the head this cycle.
- out_valid  out  1  head entry valid; 0 = bubble to decode.
- out_instr  out  WIDTH  head instruction.
- out_pc  out  PC_WIDTH  head PC.
- out_exc  out  EXC_WIDTH  head exception code.
- fetch_stall  out  1  fetch must not issue a new request this cycle.
- count  out  $clog2(DEPTH+1)  current occupancy.
- overflow  out  1  sticky error flag.

Behaviour:
- State: storage array, rd_ptr and wr_ptr ($clog2(DEPTH) bits, natural wrap from DEPTH-1 to 0), count, discard counter, overflow.
- Reset (rst=1 at a clk edge):
  - count=0, both pointers=0, discard counter=0, overflow=0.
  - Resulting outputs: out_valid=0, fetch_stall=0, count=0, overflow=0.
  - out_instr, out_pc, out_exc are 0 after reset; storage array is cleared.
  - Reset has priority over halt, clk_en and flush.
- Freeze: when halt=1 or clk_en=0, no state changes. Outputs stay a function of held state.
- Output timing:
  - out_* is combinational from the head (FWFT). A push into an empty queue becomes visible at out_* the cycle after it is written; there is no same-cycle bypass.
  - out_valid = (count != 0).
- pop = out_valid && !stall && !flush.
- accept (push) = in_valid && !flush && (discard counter == 0) && (count < DEPTH || pop).
  - Push and pop in the same cycle: count unchanged; both pointers advance.
  - Push into full with a simultaneous pop is legal.
- Overflow:
  - Condition: in_valid && !flush && discard counter == 0 && count == DEPTH && !pop.
  - Effect: the word is dropped, overflow is set to 1, and it stays 1 until reset.
  - Queue contents are unaffected.
- fetch_stall = (count >= DEPTH - SKID). Combinational from registered count. This guarantees that SKID in-flight words always have space.
- Flush:
  - Takes effect at the edge: count=0 and rd_ptr=wr_ptr=0.
  - Any same-cycle input is dropped and any same-cycle pop is suppressed.
  - Discard counter is loaded with FLUSH_DISCARD.
- Discard counter:
  - Decrements by 1 on each enabled cycle while nonzero.
  - While nonzero, in_valid words are dropped silently; overflow is not set.
  - A flush during the discard window reloads the counter.
  - With FLUSH_DISCARD=0, discard is disabled.
- Exceptions: entries with in_exc != 0 are queued and popped like normal entries; the code travels with its instruction.
- Stall: while decode stalls, the head and out_* are held stable with no re-fetch. This holds for stalls of any length, replacing the fixed two-cycle buffering.

Test Plan:
- Reset, then 3 consecutive pushes with stall=0 (instr 0x11/0x22/0x33, pc 0/4/8) -> out_valid rises the cycle after the first push; decode sees 0x11, 0x22, 0x33 in order; count peaks at 1.
- stall=1 while pushing 4 words with DEPTH=4, SKID=2 -> count reaches 2 and fetch_stall=1; count reaches 4; out_instr holds the first word throughout; a 5th push sets overflow=1 and the word is dropped; releasing stall drains exactly the 4 words in order.
- Full queue (count=4), in_valid with stall=0 -> push and pop in the same cycle; count stays 4; overflow stays 0; ordering is preserved across pointer wrap (at least 10 words).
- Flush with count=3 and in_valid=1, FLUSH_DISCARD=2 -> next cycle count=0 and out_valid=0; in_valid words in the 2 following cycles are ignored; the 3rd-cycle word is accepted; a flush during the window restarts the 2-cycle discard.
- halt=1 (then clk_en=0) for 5 cycles with in_valid and stall toggling -> count, out_* and overflow are unchanged; rst asserted during halt clears everything.
- Push a word with in_exc=0x80, then a normal word -> out_exc=0x80 with its PC, followed by out_exc=0.
